// File: rtl/game_pkg.sv
// Shared definitions for the game timer blocks.
//   - State codes exported on state_out (IDLE..OVER) and the matching FSM enum.
//   - Timing defaults: 100 ms prescaler divide at 10 MHz, ready countdown and round limit.
// The display and score blocks decode state_out with these same codes.
package game_pkg;

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] READY = 3'd1;
  localparam logic [2:0] RUN   = 3'd2;
  localparam logic [2:0] PAUSE = 3'd3;
  localparam logic [2:0] OVER  = 3'd4;

  typedef enum logic [2:0] {
    ST_IDLE  = IDLE,
    ST_READY = READY,
    ST_RUN   = RUN,
    ST_PAUSE = PAUSE,
    ST_OVER  = OVER
  } state_t;

  localparam int TICK_DIV_100MS      = 1000000;
  localparam int READY_TICKS_DEFAULT = 30;
  localparam int LIMIT_TICKS_DEFAULT = 600;

  // States in which the prescaler is allowed to advance.
  function automatic logic is_timing(input state_t s);
    return (s == ST_READY) || (s == ST_RUN);
  endfunction

endpackage

// File: rtl/game_round_controller_if.sv
// Button and status bundle between the board/game logic and game_round_controller.
//   START, PAUSE, STOP : raw active-high buttons (asynchronous to CLOCK10M)
//   counter_out        : elapsed round time in tenths of a second
//   ready_out          : remaining ready-countdown ticks
//   state_out          : current state code (game_pkg IDLE..OVER)
//   running            : high while in RUN
//   timeout            : one-cycle pulse when the round limit is reached
// master = board/game side, slave = the controller.
interface game_round_controller_if #(
  parameter int WIDTH = 10
);
  logic             START;
  logic             PAUSE;
  logic             STOP;
  logic [WIDTH-1:0] counter_out;
  logic [5:0]       ready_out;
  logic [2:0]       state_out;
  logic             running;
  logic             timeout;

  modport master (
    output START, PAUSE, STOP,
    input  counter_out, ready_out, state_out, running, timeout
  );

  modport slave (
    input  START, PAUSE, STOP,
    output counter_out, ready_out, state_out, running, timeout
  );
endinterface

// File: rtl/tick_gen.sv
// Free-running prescaler producing one tick every TICK_DIV enabled cycles.
//   CLOCK10M : clock
//   RESET    : synchronous active-high reset, clears the count
//   en       : advance the count this cycle (count is frozen otherwise)
//   clr      : restart the count from 0
//   tick     : high while the count sits at TICK_DIV-1
// tick is a pure decode of the count so a consumer may change en in the same
// cycle it sees the tick without forming a loop; the consumer qualifies tick
// with its own state.
module tick_gen #(
  parameter int TICK_DIV = 1000000
) (
  input  logic CLOCK10M,
  input  logic RESET,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam int            CW   = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] count;

  always_ff @(posedge CLOCK10M) begin
    if (RESET || clr) begin
      count <= '0;
    end else if (en) begin
      count <= (count == LAST) ? '0 : count + CW'(1);
    end
  end

  assign tick = (count == LAST);

endmodule

// File: rtl/game_round_controller.sv
// Round sequencer for the 0.1 s game timer: conditions the three buttons,
// owns the 100 ms prescaler and the tenths-of-second elapsed counter, and walks
// IDLE -> READY (countdown) -> RUN <-> PAUSE -> OVER.
//   CLOCK10M : 10 MHz clock, all logic on the rising edge
//   RESET    : synchronous active-high reset, overrides everything
//   game_if  : buttons in, counter/ready/state/running/timeout out (all registered)
module game_round_controller
  import game_pkg::*;
#(
  parameter int TICK_DIV    = TICK_DIV_100MS,
  parameter int READY_TICKS = READY_TICKS_DEFAULT,
  parameter int LIMIT_TICKS = LIMIT_TICKS_DEFAULT,
  parameter int WIDTH       = 10
) (
  input  logic                    CLOCK10M,
  input  logic                    RESET,
  game_round_controller_if.slave  game_if
);

  localparam logic [5:0]       READY_INIT = 6'(READY_TICKS);
  localparam logic [WIDTH-1:0] LIMIT_LAST = WIDTH'(LIMIT_TICKS - 1);

  // Button conditioning, one lane per button: bit 0 START, 1 PAUSE, 2 STOP.
  // Two synchronizer stages, a history flop, and a registered rising edge.
  logic [2:0] btn_meta, btn_sync, btn_prev, btn_edge;
  logic       start_e, pause_e, stop_e;

  always_ff @(posedge CLOCK10M) begin
    if (RESET) begin
      btn_meta <= '0;
      btn_sync <= '0;
      btn_prev <= '0;
      btn_edge <= '0;
    end else begin
      // NOTE: non-blocking so every stage samples the previous stage's old value.
      btn_meta <= {game_if.STOP, game_if.PAUSE, game_if.START};
      btn_sync <= btn_meta;
      btn_prev <= btn_sync;
      btn_edge <= btn_sync & ~btn_prev;
    end
  end

  assign start_e = btn_edge[0];
  assign pause_e = btn_edge[1];
  assign stop_e  = btn_edge[2];

  state_t           state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic [5:0]       ready_q, ready_d;
  logic             timeout_q, timeout_d;
  logic             running_q;
  logic             tick, presc_en, presc_clr;

  // A PAUSE accepted without a coincident tick freezes the prescaler on that
  // same edge, so resume continues from the value seen when PAUSE was taken.
  // With a coincident tick the count wraps first (the tick is counted).
  assign presc_en = is_timing(state_q) &&
                    !((state_q == ST_RUN) && pause_e && !stop_e && !tick);

  tick_gen #(.TICK_DIV(TICK_DIV)) u_tick_gen (
    .CLOCK10M (CLOCK10M),
    .RESET    (RESET),
    .en       (presc_en),
    .clr      (presc_clr),
    .tick     (tick)
  );

  // Edge priority is STOP > PAUSE > START; a STOP discards a coincident tick.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    state_d   = state_q;
    count_d   = count_q;
    ready_d   = ready_q;
    timeout_d = 1'b0;
    presc_clr = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (start_e) begin
          state_d   = ST_READY;
          count_d   = '0;
          ready_d   = READY_INIT;
          presc_clr = 1'b1;
        end
      end
      ST_READY: begin
        if (stop_e) begin
          state_d = ST_IDLE;
          ready_d = '0;
        end else if (tick && (ready_q != 6'd0)) begin
          ready_d = ready_q - 6'd1;
          if (ready_q == 6'd1) state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        if (stop_e) begin
          state_d = ST_OVER;
        end else begin
          if (tick) begin
            count_d = count_q + WIDTH'(1);
            if (count_q == LIMIT_LAST) begin
              state_d   = ST_OVER;
              timeout_d = 1'b1;
            end
          end
          // Tick is counted first; reaching the limit outranks the pause.
          if (pause_e && (state_d == ST_RUN)) state_d = ST_PAUSE;
        end
      end
      ST_PAUSE: begin
        if (stop_e)                  state_d = ST_OVER;
        else if (pause_e || start_e) state_d = ST_RUN;
      end
      ST_OVER: begin
        if (stop_e) begin
          state_d = ST_IDLE;
          count_d = '0;
        end else if (start_e) begin
          state_d   = ST_READY;
          count_d   = '0;
          ready_d   = READY_INIT;
          presc_clr = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLOCK10M) begin
    if (RESET) begin
      state_q   <= ST_IDLE;
      count_q   <= '0;
      ready_q   <= '0;
      timeout_q <= 1'b0;
      running_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      ready_q   <= ready_d;
      timeout_q <= timeout_d;
      running_q <= (state_d == ST_RUN);
    end
  end

  assign game_if.counter_out = count_q;
  assign game_if.ready_out   = ready_q;
  assign game_if.state_out   = state_q;
  assign game_if.running     = running_q;
  assign game_if.timeout     = timeout_q;

endmodule

// File: tb/tb_game_round_controller.sv
// Directed bench for game_round_controller with TICK_DIV=10, READY_TICKS=3,
// LIMIT_TICKS=5. Expected (state, counter, ready, timeout, latency) records are
// queued when a button is driven and popped when the DUT reaches that result.
module tb_game_round_controller;
  import game_pkg::*;

  localparam int TD = 10;
  localparam int RT = 3;
  localparam int LT = 5;
  localparam int W  = 10;

  localparam int B_START = 0;
  localparam int B_PAUSE = 1;
  localparam int B_STOP  = 2;

  logic clock10m = 1'b0;
  logic reset    = 1'b1;

  always #5 clock10m = ~clock10m;

  game_round_controller_if #(.WIDTH(W)) bus ();

  game_round_controller #(
    .TICK_DIV    (TD),
    .READY_TICKS (RT),
    .LIMIT_TICKS (LT),
    .WIDTH       (W)
  ) dut (
    .CLOCK10M (clock10m),
    .RESET    (reset),
    .game_if  (bus)
  );

  typedef struct {
    string          tag;
    logic [2:0]     st;
    logic [W-1:0]   cnt;
    logic [5:0]     rdy;
    logic           to;
    int             lat;
  } exp_t;

  exp_t sb[$];
  int   vectors        = 0;
  int   miscompares    = 0;
  int   timeout_pulses = 0;

  always @(negedge clock10m) begin
    if (bus.timeout === 1'b1) timeout_pulses++;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clock10m);
  endtask

  task automatic set_btn(input int which, input logic v);
    case (which)
      B_START: bus.START = v;
      B_PAUSE: bus.PAUSE = v;
      default: bus.STOP  = v;
    endcase
  endtask

  task automatic expect_push(input string tag, input logic [2:0] st, input logic [W-1:0] cnt,
                             input logic [5:0] rdy, input logic to, input int lat);
    exp_t e;
    e.tag = tag; e.st = st; e.cnt = cnt; e.rdy = rdy; e.to = to; e.lat = lat;
    sb.push_back(e);
  endtask

  // Waits (bounded) for the queued result, then compares latency and outputs.
  task automatic expect_pop(input int elapsed);
    exp_t e;
    int   n;
    e = sb.pop_front();
    n = elapsed;
    while (!(bus.state_out === e.st && bus.counter_out === e.cnt && bus.ready_out === e.rdy)
           && n < e.lat + 40) begin
      @(negedge clock10m);
      n++;
    end
    check({e.tag, "_lat"},     n,                e.lat);
    check({e.tag, "_state"},   bus.state_out,    e.st);
    check({e.tag, "_counter"}, bus.counter_out,  e.cnt);
    check({e.tag, "_ready"},   bus.ready_out,    e.rdy);
    check({e.tag, "_timeout"}, bus.timeout,      e.to);
    check({e.tag, "_running"}, bus.running,      (e.st == RUN));
  endtask

  task automatic step(input string tag, input logic [2:0] st, input logic [W-1:0] cnt,
                      input logic [5:0] rdy, input logic to, input int lat);
    expect_push(tag, st, cnt, rdy, to, lat);
    expect_pop(0);
  endtask

  // Button high for 'hold' cycles; the result is due 4 sampling points after the press.
  task automatic press_expect(input int which, input int hold, input string tag,
                              input logic [2:0] st, input logic [W-1:0] cnt,
                              input logic [5:0] rdy, input logic to);
    set_btn(which, 1'b1);
    expect_push(tag, st, cnt, rdy, to, 4);
    idle(hold);
    set_btn(which, 1'b0);
    expect_pop(hold);
  endtask

  task automatic full_round(input string p);
    press_expect(B_START, 2, {p, "_ready3"}, READY, '0, 6'd3, 1'b0);
    step({p, "_ready2"}, READY, '0, 6'd2, 1'b0, TD);
    step({p, "_ready1"}, READY, '0, 6'd1, 1'b0, TD);
    step({p, "_run"},    RUN,   '0, 6'd0, 1'b0, TD);
    for (int i = 1; i < LT; i++) begin
      step($sformatf("%s_cnt%0d", p, i), RUN, W'(i), 6'd0, 1'b0, TD);
    end
    step({p, "_limit"}, OVER, W'(LT), 6'd0, 1'b1, TD);
    idle(1);
    check({p, "_timeout_low"}, bus.timeout,   1'b0);
    check({p, "_over_state"},  bus.state_out, OVER);
    idle(5);
    check({p, "_over_hold"},   bus.counter_out, W'(LT));
  endtask

  task automatic to_run_at1(input string p);
    press_expect(B_START, 1, {p, "_ready"}, READY, '0, 6'd3, 1'b0);
    step({p, "_run"}, RUN, '0, 6'd0, 1'b0, TD * RT);
    step({p, "_c1"},  RUN, W'(1), 6'd0, 1'b0, TD);
  endtask

  initial begin
    bus.START = 1'b0;
    bus.PAUSE = 1'b0;
    bus.STOP  = 1'b0;
    reset     = 1'b1;
    idle(3);
    check("reset_state",   bus.state_out,   IDLE);
    check("reset_counter", bus.counter_out, 0);
    check("reset_ready",   bus.ready_out,   0);
    check("reset_running", bus.running,     0);
    check("reset_timeout", bus.timeout,     0);
    reset = 1'b0;
    idle(2);

    // Basic round, then the identical round restarted from OVER.
    full_round("s1");
    check("s1_pulses", timeout_pulses, 1);
    full_round("s6");
    check("s6_pulses", timeout_pulses, 2);

    // Pause at counter 2 with the prescaler at 4; hold PAUSE 100 cycles.
    to_run_at1("s2");
    step("s2_c2", RUN, W'(2), 6'd0, 1'b0, TD);
    idle(1);
    bus.PAUSE = 1'b1;
    expect_push("s2_pause", PAUSE, W'(2), 6'd0, 1'b0, 4);
    expect_pop(0);
    idle(96);
    check("s2_hold_state",   bus.state_out,   PAUSE);
    check("s2_hold_counter", bus.counter_out, 2);
    bus.PAUSE = 1'b0;
    idle(3);
    press_expect(B_PAUSE, 1, "s2_resume", RUN, W'(2), 6'd0, 1'b0);
    step("s2_c3", RUN, W'(3), 6'd0, 1'b0, TD - 4);

    // Stop paths.
    press_expect(B_STOP, 2, "s3_stop_run", OVER, W'(3), 6'd0, 1'b0);
    idle(15);
    check("s3_over_hold", bus.counter_out, 3);
    check("s3_no_pulse",  timeout_pulses, 2);
    press_expect(B_STOP, 2, "s3_stop_over", IDLE, '0, 6'd0, 1'b0);
    press_expect(B_START, 1, "s3_ready", READY, '0, 6'd3, 1'b0);
    press_expect(B_STOP, 1, "s3_stop_ready", IDLE, '0, 6'd0, 1'b0);

    // STOP edge lands on the tick that would make counter 2.
    to_run_at1("s4a");
    idle(6);
    press_expect(B_STOP, 1, "s4a_stop_tick", OVER, W'(1), 6'd0, 1'b0);

    // PAUSE edge lands on the tick at counter 1: tick counted, then PAUSE.
    to_run_at1("s4b");
    idle(6);
    press_expect(B_PAUSE, 1, "s4b_pause_tick", PAUSE, W'(2), 6'd0, 1'b0);
    press_expect(B_PAUSE, 1, "s4b_resume", RUN, W'(2), 6'd0, 1'b0);
    step("s4b_c3", RUN, W'(3), 6'd0, 1'b0, TD);
    step("s4b_c4", RUN, W'(4), 6'd0, 1'b0, TD);

    // PAUSE edge lands on the limit tick: OVER wins, timeout pulses.
    idle(6);
    press_expect(B_PAUSE, 1, "s4c_pause_limit", OVER, W'(LT), 6'd0, 1'b1);
    idle(2);
    check("s4c_pulses", timeout_pulses, 3);

    // Mid-round reset at counter 4.
    to_run_at1("s5");
    step("s5_c2", RUN, W'(2), 6'd0, 1'b0, TD);
    step("s5_c3", RUN, W'(3), 6'd0, 1'b0, TD);
    step("s5_c4", RUN, W'(4), 6'd0, 1'b0, TD);
    reset = 1'b1;
    expect_push("s5_reset", IDLE, '0, 6'd0, 1'b0, 1);
    idle(1);
    reset = 1'b0;
    expect_pop(1);

    // A held START yields one edge only; a new press is needed for another.
    bus.START = 1'b1;
    expect_push("s5_held_ready", READY, '0, 6'd3, 1'b0, 4);
    expect_pop(0);
    press_expect(B_STOP, 1, "s5_stop", IDLE, '0, 6'd0, 1'b0);
    idle(30);
    check("s5_no_retrigger", bus.state_out, IDLE);
    bus.START = 1'b0;
    idle(3);
    press_expect(B_START, 1, "s5_repress", READY, '0, 6'd3, 1'b0);
    press_expect(B_STOP, 1, "s5_final_stop", IDLE, '0, 6'd0, 1'b0);
    check("final_pulses", timeout_pulses, 3);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
